// File: rtl/bist_misr_compactor.sv
// BIST signature compactor: folds a 4-bit FSM result stream into a MISR
// over a programmed window and compares the final signature with a golden value.
module bist_misr_compactor #(
  parameter int unsigned       SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED  = 16'hFFFF,
  parameter int unsigned       CNT_W = 8,
  parameter int unsigned       LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [SIG_W-1:0] golden,
  input  logic [3:0]       result_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CAPTURE,
    DONE
  } state_e;

  localparam logic [2:0] LAT_V = 3'(LAT);

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       skip_q, skip_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  always_comb begin
    sig_next = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(result_in);
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    golden_d = golden_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    pass_d   = pass_q;

    if (abort) begin
      // Abort wins over start; the signature is left frozen for inspection.
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sig_d    = SEED;
            golden_d = golden;
            cnt_d    = num_cycles;
            pass_d   = 1'b0;
            if (LAT > 0) begin
              state_d = SKIP;
              skip_d  = LAT_V;
            end else if (num_cycles == '0) begin
              state_d = DONE;
              pass_d  = (SEED == golden);
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        SKIP: begin
          if (skip_q <= 3'd1) begin
            skip_d = '0;
            if (cnt_q == '0) begin
              state_d = DONE;
              pass_d  = (sig_q == golden_q);
            end else begin
              state_d = CAPTURE;
            end
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        CAPTURE: begin
          sig_d = sig_next;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          // Last sample is absorbed on the same edge that enters DONE.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = DONE;
            pass_d  = (sig_next == golden_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SKIP) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      golden_q <= '0;
      cnt_q    <= '0;
      skip_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Bench for bist_misr_compactor: two instances (LAT=0 and LAT=1) share one
// stimulus stream; expected signatures are queued at start and popped at completion.
module tb_bist_misr_compactor;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [7:0]  num_cycles;
  logic [15:0] golden;
  logic [3:0]  result_in;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] sig0, sig1;

  always #5 clk = ~clk;

  bist_misr_compactor #(.SIG_W(16), .POLY(POLY), .SEED(SEED), .CNT_W(8), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_cycles(num_cycles),
    .golden(golden), .result_in(result_in), .busy(busy0), .done(done0), .pass(pass0),
    .signature(sig0)
  );

  bist_misr_compactor #(.SIG_W(16), .POLY(POLY), .SEED(SEED), .CNT_W(8), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_cycles(num_cycles),
    .golden(golden), .result_in(result_in), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1)
  );

  typedef struct {
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] stim [0:63];

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] r);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ POLY;
    return t ^ {12'h000, r};
  endfunction

  // Signature after absorbing stim[lat+1 .. lat+n].
  function automatic logic [15:0] model(input int lat, input int n);
    logic [15:0] s;
    s = SEED;
    for (int i = lat + 1; i <= lat + n; i++) s = misr_step(s, stim[i]);
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) stim[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_start(input int n, input logic [15:0] g);
    @(negedge clk);
    num_cycles = 8'(n);
    golden     = g;
    start      = 1'b1;
    abort      = 1'b0;
    result_in  = stim[0];
  endtask

  // inject: edge index at which a spurious start is driven while busy (0 = none).
  task automatic run(input int n, input logic [15:0] g, input int inject);
    exp_t e0, e1, p;
    drive_start(n, g);
    e0.sig = model(0, n); e0.pass = (e0.sig == g); q0.push_back(e0);
    e1.sig = model(1, n); e1.pass = (e1.sig == g); q1.push_back(e1);
    for (int k = 0; k <= n + 2; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("busy0_k%0d", k), 16'(busy0), 16'(k < n));
      check_eq($sformatf("done0_k%0d", k), 16'(done0), 16'(k >= n));
      check_eq($sformatf("busy1_k%0d", k), 16'(busy1), 16'(k < n + 1));
      check_eq($sformatf("done1_k%0d", k), 16'(done1), 16'(k >= n + 1));
      if (k == 0) begin
        check_eq("sig0_seed", sig0, SEED);
        check_eq("sig1_seed", sig1, SEED);
      end
      @(negedge clk);
      start      = (inject != 0) && (k + 1 == inject);
      num_cycles = 8'(n + 3);
      golden     = ~g;
      result_in  = stim[k + 1];
    end
    p = q0.pop_front();
    check_eq("sig0_final", sig0, p.sig);
    check_eq("pass0_final", 16'(pass0), 16'(p.pass));
    p = q1.pop_front();
    check_eq("sig1_final", sig1, p.sig);
    check_eq("pass1_final", 16'(pass1), 16'(p.pass));
  endtask

  // Abort lands on edge a (2 <= a <= n) while both instances are capturing.
  task automatic run_abort(input int n, input int a);
    exp_t e0, e1, p;
    drive_start(n, 16'h1234);
    e0.sig = model(0, a - 1); e0.pass = 1'b0; q0.push_back(e0);
    e1.sig = model(1, a - 2); e1.pass = 1'b0; q1.push_back(e1);
    for (int k = 0; k < a; k++) begin
      @(negedge clk);
      start     = 1'b0;
      abort     = (k + 1 == a);
      result_in = stim[k + 1];
    end
    @(posedge clk); #1;
    check_eq("abort_busy0", 16'(busy0), 16'h0);
    check_eq("abort_done0", 16'(done0), 16'h0);
    check_eq("abort_busy1", 16'(busy1), 16'h0);
    check_eq("abort_pass1", 16'(pass1), 16'h0);
    // Abort together with start from IDLE: abort must win, signature stays frozen.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    p = q0.pop_front();
    check_eq("abort_sig0", sig0, p.sig);
    check_eq("abort_pass0", 16'(pass0), 16'(p.pass));
    p = q1.pop_front();
    check_eq("abort_sig1", sig1, p.sig);
    check_eq("abortprio_busy1", 16'(busy1), 16'h0);
    check_eq("abortprio_done0", 16'(done0), 16'h0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_reset(input int n, input int a);
    drive_start(n, 16'h5555);
    for (int k = 0; k < a; k++) begin
      @(negedge clk);
      start     = (k + 1 == a);
      rst_n     = !(k + 1 == a);
      result_in = stim[k + 1];
    end
    @(posedge clk); #1;
    check_eq("rst_busy0", 16'(busy0), 16'h0);
    check_eq("rst_done0", 16'(done0), 16'h0);
    check_eq("rst_sig0", sig0, SEED);
    check_eq("rst_busy1", 16'(busy1), 16'h0);
    check_eq("rst_pass1", 16'(pass1), 16'h0);
    check_eq("rst_sig1", sig1, SEED);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_cycles = '0; golden = '0; result_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy0", 16'(busy0), 16'h0);
    check_eq("reset_done0", 16'(done0), 16'h0);
    check_eq("reset_pass0", 16'(pass0), 16'h0);
    check_eq("reset_sig0", sig0, SEED);
    check_eq("reset_sig1", sig1, SEED);
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample, zero input (and latency-skip case on the LAT=1 instance).
    fill_random();
    stim[1] = 4'h0; stim[2] = 4'h0;
    run(1, 16'hEFDF, 0);
    check_eq("single_zero_sig0", sig0, 16'hEFDF);
    check_eq("single_zero_pass0", 16'(pass0), 16'h1);

    // Nonzero sample in what is the skip cycle for LAT=1.
    stim[1] = 4'h3; stim[2] = 4'h0;
    run(1, 16'hEFDF, 0);
    check_eq("single_three_sig0", sig0, 16'hEFDC);
    check_eq("single_three_pass0", 16'(pass0), 16'h0);
    check_eq("skip_sig1", sig1, 16'hEFDF);
    check_eq("skip_pass1", 16'(pass1), 16'h1);

    // Zero-length run.
    run(0, 16'hFFFF, 0);
    check_eq("zero_sig0", sig0, 16'hFFFF);
    check_eq("zero_pass0", 16'(pass0), 16'h1);

    // Random runs with a spurious start while busy.
    for (int r = 0; r < 4; r++) begin
      int n;
      logic [15:0] g;
      fill_random();
      n = $urandom_range(3, 20);
      g = (r % 2 == 0) ? model(0, n) : 16'($urandom);
      run(n, g, $urandom_range(1, n));
    end

    fill_random();
    run_abort(10, 4);
    fill_random();
    run(5, 16'h0000, 2);

    fill_random();
    run_reset(8, 3);
    fill_random();
    run(2, model(1, 2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
